regfile_wb_arbiter: RTL

//  Shares the register file's single write port among NUM_REQ writeback sources (ALU, load unit, CSR, ...).

---
 rtl/regfile_wb_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback sources.
// Optional WB_FORWARD_EN: forward the in-flight writeback onto rs1_data/rs2_data.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*5-1:0]   req_rd,
  input  logic [NUM_REQ*32-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [4:0]             wb_rd,
  output logic [31:0]            wb_data,
  output logic                   wb_enable,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [31:0]            rf_rs1_data,
  input  logic [31:0]            rf_rs2_data,
  output logic [31:0]            rs1_data,
  output logic [31:0]            rs2_data,
  output logic [CNT_W-1:0]       conflict_cnt
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] ptr_next;
  logic             grant;
  logic [4:0]       sel_rd;
  logic [31:0]      sel_data;
  logic             multi_valid;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant  = 1'b1;
        winner = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign req_ready   = (grant && rst) ? (NUM_REQ'(1) << winner) : '0;
  assign ptr_next    = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  assign sel_rd      = req_rd[5*winner +: 5];
  assign sel_data    = req_data[32*winner +: 32];
  assign multi_valid = ($countones(req_valid) > 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr       <= '0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_enable    <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      if (grant) begin
        rr_ptr    <= ptr_next;
        wb_rd     <= sel_rd;
        wb_data   <= sel_data;
        // x0 writes are accepted but never reach the register file
        wb_enable <= (sel_rd != 5'd0);
      end else begin
        wb_enable <= 1'b0;
      end
      if (multi_valid && (conflict_cnt != {CNT_W{1'b1}}))
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

`ifdef WB_FORWARD_EN
  assign rs1_data = (wb_enable && (wb_rd == rs1) && (rs1 != 5'd0)) ? wb_data : rf_rs1_data;
  assign rs2_data = (wb_enable && (wb_rd == rs2) && (rs2 != 5'd0)) ? wb_data : rf_rs2_data;
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign rs1_data  = rf_rs1_data;
  assign rs2_data  = rf_rs2_data;
`endif

endmodule
